spi_sram_bus: RTL and testbench
===============================

Name: spi_sram_bus

Overview:
- Memory-bus responder that services single-byte CPU reads and writes from an external SPI serial SRAM (23LC1024-class, 24-bit address).
- Sits behind the memory bus decode: the bus drives `enable`, `write_enable`, `address` and `data_in`.
- While a transfer is in progress, the block's `busy` output is used as the CPU halt.
- Runs the SPI command sequence (READ 0x03 / WRITE 0x02) and returns read data on `data_out`.

Parameters:
- CLOCK_DIV, 2: SPI half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  bus request; held high by the bus for the duration of an access
- write_enable  input  1  1 = write, 0 = read; sampled with enable
- address  input  24  byte address sent to the SRAM
- data_in  input  8  write data
- data_out  output  8  last read byte
- busy  output  1  halt request to the CPU
- spi_cs  output  1  SRAM chip select, active low
- spi_clk  output  1  SPI clock, mode 0
- spi_do  output  1  MOSI
- spi_di  input  1  MISO

Behaviour:

Reset state (reset low, asynchronous):
- state=IDLE, spi_cs=1, spi_clk=0, spi_do=0, data_out=0.
- busy is forced 0 while reset is asserted.

States: IDLE, START, SHIFT, STOP, DONE.

IDLE:
- If enable=1, latch address, write_enable and data_in.
- Build a 40-bit shift word: {cmd, address, data}. cmd=0x02 for writes, 0x03 for reads; the data byte is 0x00 for reads.
- Next state is START.

START:
- spi_cs=0, spi_clk=0, spi_do = shift word MSB.
- Lasts CLOCK_DIV cycles.

SHIFT:
- 40 bits, MSB first, each bit lasting 2*CLOCK_DIV cycles.
- First CLOCK_DIV cycles: spi_clk=0. Last CLOCK_DIV cycles: spi_clk=1.
- spi_di is sampled on the cycle spi_clk rises.
- spi_do changes only on the cycle spi_clk falls (mode 0).
- Bits 32..39 sampled from spi_di form the read byte.
- After bit 39 completes, spi_clk=0.
- On a read, data_out is updated with the read byte at the end of SHIFT. On a write, data_out is unchanged.

STOP:
- spi_cs=1, spi_do=0.
- Lasts CLOCK_DIV cycles, then DONE.

DONE:
- If enable=0, go to IDLE.
- If enable=1 and {address, write_enable, data_in} equals the latched request, stay in DONE.
- If enable=1 and any of them differs, treat it as a new request and go to IDLE.

busy:
- busy = enable & ~(state==DONE & request matches latched).
- Combinational, so busy rises in the same cycle enable rises.

Latency:
- Request cycle is cycle 0 (IDLE).
- START covers cycles 1..CLOCK_DIV; SHIFT covers 80*CLOCK_DIV cycles; STOP covers CLOCK_DIV cycles.
- DONE is reached at cycle 1+82*CLOCK_DIV. For CLOCK_DIV=2, busy is high for cycles 0..164 and low from cycle 165.

Boundary conditions:
- enable dropped mid-transfer: the transfer completes anyway, so the SRAM is never left with a partial write. busy reads 0 while enable=0.
- New enable while an abandoned transfer is still running: busy stays high; the old transfer finishes, then DONE→IDLE, and the new request is serviced.
- reset mid-transfer: immediate return to reset state; spi_cs goes high asynchronously.
- Address width: all 24 bits are sent; no wrap or masking is applied inside the block.
- Single clock domain; spi_di is sampled directly with no synchroniser, since the SRAM is clocked by spi_clk.

Test Plan:
1. Read, CLOCK_DIV=2, address=0x012345, SRAM model returns 0xA5 → MOSI carries 0x03,0x01,0x23,0x45,0x00; data_out=0xA5; busy high for cycles 0..164 and low at cycle 165; spi_cs low for exactly 162 cycles.
2. Write, address=0x00ABCD, data_in=0x5A → MOSI carries 0x02,0x00,0xAB,0xCD,0x5A; data_out holds its previous value; subsequent read of 0x00ABCD returns 0x5A.
3. enable held high, address changed from 0x000010 to 0x000011 while in DONE → busy reasserts in the same cycle; a second complete READ frame is sent.
4. enable dropped at cycle 40 of a write to 0x000020 with data 0x33, then reasserted for a read of 0x000020 → write frame completes intact, then read frame; data_out=0x33.
5. reset pulsed low at cycle 60 of a read → spi_cs=1, spi_clk=0, data_out=0 immediately; after release, a new read completes normally.
6. CLOCK_DIV=1, read of 0xFFFFFF returning 0x81 → spi_clk period 2 cycles; busy low at cycle 83; data_out=0x81.

Source files
------------

// File: rtl/spi_sram_bus.sv
// -----------------------------------------------------------------------------
// spi_sram_bus
//   Memory-bus responder for single-byte CPU accesses to an external SPI
//   serial SRAM (23LC1024-class, 24-bit address, SPI mode 0).
//   Each access sends one 40-bit frame {cmd, address[23:0], data}:
//     - reads:  cmd 0x03, data byte 0x00, the last 8 MISO bits form the result
//     - writes: cmd 0x02, data byte = write data
//   `busy` is the CPU halt. It is high while the bus requests an access that
//   has not yet been completed.
//
// Parameters
//   CLOCK_DIV     SPI half-period in clk cycles (1..255)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        bus request, held high by the bus for the whole access
//   write_enable  1 = write, 0 = read (sampled with enable)
//   address       24-bit SRAM byte address
//   data_in       write data
//   data_out      last byte read from the SRAM
//   busy          halt request to the CPU
//   spi_cs        SRAM chip select, active low
//   spi_clk       SPI clock, mode 0 (idles low)
//   spi_do        MOSI
//   spi_di        MISO
// -----------------------------------------------------------------------------
module spi_sram_bus #(
  parameter int CLOCK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        write_enable,
  input  logic [23:0] address,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_do,
  input  logic        spi_di
);

  localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'd39;
  localparam logic [7:0] CMD_WR   = 8'h02;
  localparam logic [7:0] CMD_RD   = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_STOP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_cnt;       // cycle count within the current half-period
  logic        r_phase;     // 0 = spi_clk low half, 1 = spi_clk high half
  logic [5:0]  r_bit;       // frame bit index, 0..39
  logic [39:0] r_shift;     // outgoing frame, MSB drives spi_do
  logic [7:0]  r_rx;        // last 8 sampled MISO bits
  logic [7:0]  r_data_out;
  logic [23:0] r_addr;
  logic        r_we;
  logic [7:0]  r_wdata;

  logic        w_half_end;
  logic        w_match;
  logic        w_frame;

  assign w_half_end = (r_cnt == DIV_LAST);

  // The bus holds a request steady until busy drops. Any change of the
  // request fields while enable is high counts as a new access.
  assign w_match = enable && (address == r_addr) && (write_enable == r_we) &&
                   (data_in == r_wdata);

  assign w_frame = (r_state == S_START) || (r_state == S_SHIFT);

  // SPI pins are pure decodes of registered state, so an asynchronous reset
  // releases chip select immediately.
  assign spi_cs   = ~w_frame;
  assign spi_clk  = (r_state == S_SHIFT) && r_phase;
  assign spi_do   = w_frame ? r_shift[39] : 1'b0;
  assign data_out = r_data_out;

  // Combinational so the CPU halts in the same cycle it raises enable.
  // Once enable drops, an abandoned transfer keeps running but does not halt.
  assign busy = reset & enable & ~((r_state == S_DONE) & w_match);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_START;
      S_START: if (w_half_end) w_next = S_SHIFT;
      S_SHIFT: if (w_half_end && r_phase && (r_bit == LAST_BIT)) w_next = S_STOP;
      S_STOP:  if (w_half_end) w_next = S_DONE;
      S_DONE:  if (!w_match) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, bit timing, shift registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_phase    <= 1'b0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
          r_bit   <= '0;
          if (enable) begin
            r_addr  <= address;
            r_we    <= write_enable;
            r_wdata <= data_in;
            r_shift <= write_enable ? {CMD_WR, address, data_in}
                                    : {CMD_RD, address, 8'h00};
          end
        end

        S_START: begin
          r_phase <= 1'b0;
          r_bit   <= '0;
          r_cnt   <= w_half_end ? 8'd0 : r_cnt + 8'd1;
        end

        S_SHIFT: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (!r_phase) begin
              // spi_clk rises: sample MISO
              r_phase <= 1'b1;
              r_rx    <= {r_rx[6:0], spi_di};
            end else begin
              // spi_clk falls: present the next MOSI bit
              r_phase <= 1'b0;
              r_shift <= {r_shift[38:0], 1'b0};
              r_bit   <= r_bit + 6'd1;
              if ((r_bit == LAST_BIT) && !r_we) r_data_out <= r_rx;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_STOP: begin
          r_phase <= 1'b0;
          r_cnt   <= w_half_end ? 8'd0 : r_cnt + 8'd1;
        end

        default: begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_bus.sv
module tb_spi_sram_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // DUT 0: CLOCK_DIV = 2
  logic        en0, we0;
  logic [23:0] addr0;
  logic [7:0]  din0, dout0;
  logic        busy0, cs0, sck0, do0;

  // DUT 1: CLOCK_DIV = 1
  logic        en1, we1;
  logic [23:0] addr1;
  logic [7:0]  din1, dout1;
  logic        busy1, cs1, sck1, do1;

  logic        miso;
  logic        sel;   // which DUT the SRAM model listens to

  spi_sram_bus #(.CLOCK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .write_enable(we0),
    .address(addr0), .data_in(din0), .data_out(dout0), .busy(busy0),
    .spi_cs(cs0), .spi_clk(sck0), .spi_do(do0), .spi_di(miso));

  spi_sram_bus #(.CLOCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .write_enable(we1),
    .address(addr1), .data_in(din1), .data_out(dout1), .busy(busy1),
    .spi_cs(cs1), .spi_clk(sck1), .spi_do(do1), .spi_di(miso));

  wire m_cs   = sel ? cs1  : cs0;
  wire m_sck  = sel ? sck1 : sck0;
  wire m_mosi = sel ? do1  : do0;

  // ---------------------------------------------------------------------------
  // SPI SRAM model (mode 0): shifts MOSI in on rising spi_clk, drives MISO on
  // falling spi_clk, and commits a write only when a full 40-bit frame ended.
  // ---------------------------------------------------------------------------
  logic [7:0]  wmem [int];
  logic [39:0] frames [$];
  logic [39:0] m_sh = '0;
  int          m_cnt = 0;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;

  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'h012345: rom = 8'hA5;
      24'h000010: rom = 8'h11;
      24'h000011: rom = 8'h22;
      24'h000030: rom = 8'h44;
      24'hFFFFFF: rom = 8'h81;
      default:    rom = 8'h00;
    endcase
  endfunction

  always @(m_sck or posedge m_cs) begin
    logic [7:0] b;
    if (m_cs) begin
      if (m_cnt == 40) begin
        frames.push_back(m_sh);
        if (m_cmd == 8'h02) wmem[int'(m_addr)] = m_sh[7:0];
      end
      m_cnt = 0;
      miso  = 1'b0;
    end else if (m_sck) begin
      m_sh  = {m_sh[38:0], m_mosi};
      m_cnt = m_cnt + 1;
      if (m_cnt == 32) begin
        m_cmd  = m_sh[31:24];
        m_addr = m_sh[23:0];
      end
    end else if (m_cnt >= 32 && m_cnt < 40 && m_cmd == 8'h03) begin
      b    = wmem.exists(int'(m_addr)) ? wmem[int'(m_addr)] : rom(m_addr);
      miso = b[39 - m_cnt];
    end
  end

  initial miso = 1'b0;

  // MOSI may only move on a falling spi_clk while chip select is held low.
  int   viol = 0;
  logic p_cs = 1'b1, p_sck = 1'b0, p_do = 1'b0;
  always @(negedge clk) begin
    if (!p_cs && !cs0 && (do0 !== p_do) && !(p_sck && !sck0)) viol <= viol + 1;
    p_cs  <= cs0;
    p_sck <= sck0;
    p_do  <= do0;
  end

  // ---------------------------------------------------------------------------
  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic w, input logic [23:0] a, input logic [7:0] d);
    en0 = 1'b1; we0 = w; addr0 = a; din0 = d;
  endtask

  // Runs from the current cycle (cycle 0) until busy0 drops; returns the
  // cycle of the drop (-1 on timeout) and the number of cycles cs0 was low.
  task automatic wait_done0(output int lowc, output int csl);
    lowc = -1;
    csl  = 0;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (!cs0) csl++;
      if (!busy0) begin
        lowc = c;
        break;
      end
    end
  endtask

  initial begin
    int lowc, csl, nf, r1, r2;
    logic psck;

    sel = 1'b0;
    reset = 1'b0;
    en0 = 1'b1; we0 = 1'b0; addr0 = '0; din0 = '0;
    en1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) step();

    // Reset state, with enable high to show busy is forced low
    check("rst_cs",   64'(cs0),   64'd1);
    check("rst_sck",  64'(sck0),  64'd0);
    check("rst_do",   64'(do0),   64'd0);
    check("rst_dout", 64'(dout0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    en0 = 1'b0;
    reset = 1'b1;
    step();

    // 1: read 0x012345 -> 0xA5
    start0(1'b0, 24'h012345, 8'h00);
    #1;
    check("t1_busy_c0", 64'(busy0), 64'd1);
    wait_done0(lowc, csl);
    check("t1_busy_low_cyc", 64'(lowc), 64'd165);
    check("t1_cs_low_cycles", 64'(csl), 64'd162);
    check("t1_dout", 64'(dout0), 64'hA5);
    check("t1_nframes", 64'(frames.size()), 64'd1);
    check("t1_frame", 64'(frames[0]), 64'h03_012345_00);
    en0 = 1'b0;
    step();

    // 2: write 0x00ABCD <- 0x5A, then read it back
    start0(1'b1, 24'h00ABCD, 8'h5A);
    wait_done0(lowc, csl);
    check("t2_wr_busy_low_cyc", 64'(lowc), 64'd165);
    check("t2_wr_dout_held", 64'(dout0), 64'hA5);
    check("t2_wr_frame", 64'(frames[frames.size()-1]), 64'h02_00ABCD_5A);
    check("t2_mem", 64'(wmem.exists(32'h00ABCD) ? wmem[32'h00ABCD] : 8'hxx), 64'h5A);
    en0 = 1'b0;
    step();
    start0(1'b0, 24'h00ABCD, 8'h00);
    wait_done0(lowc, csl);
    check("t2_rd_dout", 64'(dout0), 64'h5A);
    check("t2_rd_frame", 64'(frames[frames.size()-1]), 64'h03_00ABCD_00);
    en0 = 1'b0;
    step();

    // 3: address changes while enable stays high in DONE
    start0(1'b0, 24'h000010, 8'h00);
    wait_done0(lowc, csl);
    check("t3_first_dout", 64'(dout0), 64'h11);
    step();
    check("t3_done_hold_busy", 64'(busy0), 64'd0);
    nf = frames.size();
    addr0 = 24'h000011;
    #1;
    check("t3_reassert", 64'(busy0), 64'd1);
    wait_done0(lowc, csl);
    check("t3_busy_low_cyc", 64'(lowc), 64'd166);
    check("t3_nframes", 64'(frames.size()), 64'(nf + 1));
    check("t3_frame", 64'(frames[frames.size()-1]), 64'h03_000011_00);
    check("t3_dout", 64'(dout0), 64'h22);
    en0 = 1'b0;
    step();

    // 4: write abandoned at cycle 40, read of same address at cycle 50
    nf = frames.size();
    start0(1'b1, 24'h000020, 8'h33);
    repeat (40) step();
    en0 = 1'b0;
    #1;
    check("t4_busy_dropped", 64'(busy0), 64'd0);
    repeat (10) step();
    start0(1'b0, 24'h000020, 8'h00);
    #1;
    check("t4_busy_reassert", 64'(busy0), 64'd1);
    wait_done0(lowc, csl);
    check("t4_busy_low_cyc", 64'(lowc), 64'd281);
    check("t4_nframes", 64'(frames.size()), 64'(nf + 2));
    check("t4_wr_frame", 64'(frames[nf]), 64'h02_000020_33);
    check("t4_rd_frame", 64'(frames[nf+1]), 64'h03_000020_00);
    check("t4_dout", 64'(dout0), 64'h33);
    en0 = 1'b0;
    step();

    // 5: reset pulsed at cycle 60 of a read
    nf = frames.size();
    start0(1'b0, 24'h000030, 8'h00);
    repeat (60) step();
    check("t5_cs_before", 64'(cs0), 64'd0);
    reset = 1'b0;
    #1;
    check("t5_rst_cs", 64'(cs0), 64'd1);
    check("t5_rst_sck", 64'(sck0), 64'd0);
    check("t5_rst_dout", 64'(dout0), 64'd0);
    check("t5_rst_busy", 64'(busy0), 64'd0);
    step();
    reset = 1'b1;
    wait_done0(lowc, csl);
    check("t5_busy_low_cyc", 64'(lowc), 64'd165);
    check("t5_nframes", 64'(frames.size()), 64'(nf + 1));
    check("t5_frame", 64'(frames[frames.size()-1]), 64'h03_000030_00);
    check("t5_dout", 64'(dout0), 64'h44);
    en0 = 1'b0;
    step();

    check("mosi_mode0_violations", 64'(viol), 64'd0);

    // 6: CLOCK_DIV = 1, read 0xFFFFFF -> 0x81
    sel = 1'b1;
    step();
    en1 = 1'b1; we1 = 1'b0; addr1 = 24'hFFFFFF; din1 = 8'h00;
    #1;
    check("t6_busy_c0", 64'(busy1), 64'd1);
    lowc = -1; csl = 0; r1 = -1; r2 = -1; psck = sck1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (!cs1) csl++;
      if (sck1 && !psck) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      psck = sck1;
      if (!busy1) begin
        lowc = c;
        break;
      end
    end
    check("t6_busy_low_cyc", 64'(lowc), 64'd83);
    check("t6_cs_low_cycles", 64'(csl), 64'd81);
    check("t6_sck_period", 64'(r2 - r1), 64'd2);
    check("t6_frame", 64'(frames[frames.size()-1]), 64'h03_FFFFFF_00);
    check("t6_dout", 64'(dout1), 64'h81);
    en1 = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
